// File: rtl/fht_stage_seq.sv
// FHT stage sequencer: issues butterfly read/twiddle addresses per stage,
// delays them through the memory+butterfly latency and emits write-backs.
module fht_stage_seq #(
  parameter int A_BIT   = 10,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 3
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iSTART,
  output logic                   oRD_EN,
  output logic [A_BIT-1:0]       oRD_ADDR_0,
  output logic [A_BIT-1:0]       oRD_ADDR_1,
  output logic [A_BIT-1:0]       oRD_ADDR_2,
  output logic [A_BIT-2:0]       oTW_ADDR,
  output logic                   oWE,
  output logic [A_BIT-1:0]       oWR_ADDR_0,
  output logic [A_BIT-1:0]       oWR_ADDR_1,
  output logic                   oBANK_SEL,
  output logic [$clog2(A_BIT):0] oSTAGE,
  output logic                   oBUSY,
  output logic                   oRDY
);

  localparam int L  = RD_LAT + BUT_LAT;
  localparam int KW = A_BIT - 1;
  localparam int SW = $clog2(A_BIT) + 1;
  localparam int CW = $clog2(L + 1);
  localparam logic [A_BIT-1:0] ONE = A_BIT'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state, w_nstate;
  logic [KW-1:0]   r_k, w_nk;
  logic [SW-1:0]   r_stage, w_nstage;
  logic [CW-1:0]   r_dcnt, w_ndcnt;
  logic            r_bank, w_nbank;

  logic            r_rd_en;
  logic [A_BIT-1:0] r_a0, r_a1, r_a2;
  logic [A_BIT-2:0] r_tw;
  logic            r_busy, r_rdy;

  logic            r_dv [L];
  logic [A_BIT-1:0] r_d0 [L];
  logic [A_BIT-1:0] r_d1 [L];

  logic [A_BIT-1:0] w_half, w_mask, w_kx, w_j;
  logic [A_BIT-1:0] w_base, w_x2;
  logic [A_BIT-1:0] w_a0, w_a1, w_a2;
  logic [SW-1:0]   w_tsh;
  logic [A_BIT-2:0] w_tw;
  logic            w_run;

  // Next-state and counter update for the stage/butterfly sequencing
  always_comb begin
    w_nstate = r_state;
    w_nk     = r_k;
    w_nstage = r_stage;
    w_ndcnt  = r_dcnt;
    w_nbank  = r_bank;
    unique case (r_state)
      S_IDLE: begin
        if (iSTART) begin
          w_nstate = S_RUN;
          w_nk     = '0;
          w_nstage = '0;
          w_nbank  = 1'b0;
        end
      end
      S_RUN: begin
        if (r_k == {KW{1'b1}}) begin
          w_nstate = S_DRAIN;
          w_ndcnt  = '0;
        end else begin
          w_nk = r_k + KW'(1);
        end
      end
      S_DRAIN: begin
        if (r_dcnt == CW'(L - 1)) begin
          if (r_stage == SW'(A_BIT - 1)) begin
            w_nstate = S_DONE;
          end else begin
            w_nstate = S_RUN;
            w_nstage = r_stage + SW'(1);
            w_nbank  = ~r_bank;
            w_nk     = '0;
          end
        end else begin
          w_ndcnt = r_dcnt + CW'(1);
        end
      end
      S_DONE: w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Butterfly address and twiddle index for the upcoming (k, stage)
  always_comb begin
    w_run  = (w_nstate == S_RUN);
    w_half = ONE << w_nstage;
    w_mask = w_half - ONE;
    w_kx   = {1'b0, w_nk};
    w_j    = w_kx & w_mask;
    w_base = (w_kx & ~w_mask) << 1;
    w_x2   = (w_half - w_j) & w_mask;
    w_a0   = w_base | w_j;
    w_a1   = w_base | w_half | w_j;
    w_a2   = w_base | w_half | w_x2;
    w_tsh  = SW'(A_BIT - 1) - w_nstage;
    w_tw   = w_j[A_BIT-2:0] << w_tsh;
  end

  // State, counters, registered outputs and the write-address delay line
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
      r_bank  <= 1'b0;
      r_rd_en <= 1'b0;
      r_a0    <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_tw    <= '0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
      for (int i = 0; i < L; i++) begin
        r_dv[i] <= 1'b0;
        r_d0[i] <= '0;
        r_d1[i] <= '0;
      end
    end else begin
      r_state <= w_nstate;
      r_k     <= w_nk;
      r_stage <= w_nstage;
      r_dcnt  <= w_ndcnt;
      r_bank  <= w_nbank;
      r_rd_en <= w_run;
      r_a0    <= w_run ? w_a0 : '0;
      r_a1    <= w_run ? w_a1 : '0;
      r_a2    <= w_run ? w_a2 : '0;
      r_tw    <= w_run ? w_tw : '0;
      r_busy  <= (w_nstate == S_RUN) || (w_nstate == S_DRAIN);
      r_rdy   <= (w_nstate == S_DONE);
      r_dv[0] <= r_rd_en;
      r_d0[0] <= r_a0;
      r_d1[0] <= r_a1;
      for (int i = 1; i < L; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_d0[i] <= r_d0[i-1];
        r_d1[i] <= r_d1[i-1];
      end
    end
  end

  assign oRD_EN     = r_rd_en;
  assign oRD_ADDR_0 = r_a0;
  assign oRD_ADDR_1 = r_a1;
  assign oRD_ADDR_2 = r_a2;
  assign oTW_ADDR   = r_tw;
  assign oWE        = r_dv[L-1];
  assign oWR_ADDR_0 = r_d0[L-1];
  assign oWR_ADDR_1 = r_d1[L-1];
  assign oBANK_SEL  = r_bank;
  assign oSTAGE     = r_stage;
  assign oBUSY      = r_busy;
  assign oRDY       = r_rdy;

endmodule

// File: tb/tb_fht_stage_seq.sv
// Bench for fht_stage_seq with N=8 (A_BIT=3), L=4: read/write address
// tables per stage, restart-ignore, reset-in-drain abort and restart.
module tb_fht_stage_seq;

  localparam int A_BIT = 3;

  logic       iCLK, iRESET, iSTART;
  logic       oRD_EN, oWE, oBANK_SEL, oBUSY, oRDY;
  logic [2:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2;
  logic [1:0] oTW_ADDR;
  logic [2:0] oWR_ADDR_0, oWR_ADDR_1;
  logic [2:0] oSTAGE;

  int n_chk;
  int n_fail;

  typedef struct {
    int a0;
    int a1;
    int a2;
    int tw;
    int bank;
  } rd_t;

  rd_t tbl [12];

  fht_stage_seq #(.A_BIT(3), .RD_LAT(1), .BUT_LAT(3)) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iSTART     (iSTART),
    .oRD_EN     (oRD_EN),
    .oRD_ADDR_0 (oRD_ADDR_0),
    .oRD_ADDR_1 (oRD_ADDR_1),
    .oRD_ADDR_2 (oRD_ADDR_2),
    .oTW_ADDR   (oTW_ADDR),
    .oWE        (oWE),
    .oWR_ADDR_0 (oWR_ADDR_0),
    .oWR_ADDR_1 (oWR_ADDR_1),
    .oBANK_SEL  (oBANK_SEL),
    .oSTAGE     (oSTAGE),
    .oBUSY      (oBUSY),
    .oRDY       (oRDY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string n, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", n, c, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input int c);
    chk({tag, " rd_en"}, c, 32'(oRD_EN), 0);
    chk({tag, " rd0"},   c, 32'(oRD_ADDR_0), 0);
    chk({tag, " rd1"},   c, 32'(oRD_ADDR_1), 0);
    chk({tag, " rd2"},   c, 32'(oRD_ADDR_2), 0);
    chk({tag, " tw"},    c, 32'(oTW_ADDR), 0);
    chk({tag, " we"},    c, 32'(oWE), 0);
    chk({tag, " wr0"},   c, 32'(oWR_ADDR_0), 0);
    chk({tag, " wr1"},   c, 32'(oWR_ADDR_1), 0);
    chk({tag, " busy"},  c, 32'(oBUSY), 0);
    chk({tag, " rdy"},   c, 32'(oRDY), 0);
  endtask

  // Pulse start, then check ncyc cycles counted from the first RUN cycle
  task automatic run_cycles(input int ncyc, input bit poke);
    int s, p, idx, wc, widx, sc;
    bit rd, we;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      s   = c / 8;
      p   = c % 8;
      sc  = (s > 2) ? 2 : s;
      rd  = (c < 24) && (p < 4);
      idx = sc * 4 + p;
      wc  = c - 4;
      we  = (c >= 4) && (c < 24) && ((wc % 8) < 4);
      widx = we ? (wc / 8) * 4 + (wc % 8) : 0;
      chk("rd_en", c, 32'(oRD_EN), 32'(rd));
      chk("rd0", c, 32'(oRD_ADDR_0), rd ? tbl[idx].a0 : 0);
      chk("rd1", c, 32'(oRD_ADDR_1), rd ? tbl[idx].a1 : 0);
      chk("rd2", c, 32'(oRD_ADDR_2), rd ? tbl[idx].a2 : 0);
      chk("tw",  c, 32'(oTW_ADDR),   rd ? tbl[idx].tw : 0);
      chk("we",  c, 32'(oWE), 32'(we));
      chk("wr0", c, 32'(oWR_ADDR_0), we ? tbl[widx].a0 : 0);
      chk("wr1", c, 32'(oWR_ADDR_1), we ? tbl[widx].a1 : 0);
      chk("bank", c, 32'(oBANK_SEL), tbl[sc * 4].bank);
      chk("stage", c, 32'(oSTAGE), sc);
      chk("busy", c, 32'(oBUSY), (c < 24) ? 1 : 0);
      chk("rdy",  c, 32'(oRDY), (c == 24) ? 1 : 0);
      iSTART = (poke && c == 1) ? 1'b1 : 1'b0;
      @(negedge iCLK);
    end
    iSTART = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = '{0, 1, 1, 0, 0};
    tbl[1]  = '{2, 3, 3, 0, 0};
    tbl[2]  = '{4, 5, 5, 0, 0};
    tbl[3]  = '{6, 7, 7, 0, 0};
    tbl[4]  = '{0, 2, 2, 0, 1};
    tbl[5]  = '{1, 3, 3, 2, 1};
    tbl[6]  = '{4, 6, 6, 0, 1};
    tbl[7]  = '{5, 7, 7, 2, 1};
    tbl[8]  = '{0, 4, 4, 0, 0};
    tbl[9]  = '{1, 5, 7, 1, 0};
    tbl[10] = '{2, 6, 6, 2, 0};
    tbl[11] = '{3, 7, 5, 3, 0};

    // Reset held with start asserted: everything stays cleared
    iRESET = 1'b1;
    iSTART = 1'b1;
    repeat (3) @(negedge iCLK);
    chk_quiet("rst", 0);
    chk("rst bank", 0, 32'(oBANK_SEL), 0);
    chk("rst stage", 0, 32'(oSTAGE), 0);
    iSTART = 1'b0;
    iRESET = 1'b0;
    repeat (2) @(negedge iCLK);
    chk_quiet("idle", 0);

    // Full transform, with a stray start during RUN
    run_cycles(25, 1'b1);
    chk_quiet("post", 25);
    chk("post bank", 25, 32'(oBANK_SEL), 0);
    repeat (3) @(negedge iCLK);
    chk_quiet("post2", 28);

    // Abort during stage-1 DRAIN with writes pending
    run_cycles(13, 1'b0);
    iRESET = 1'b1;
    @(negedge iCLK);
    iRESET = 1'b0;
    chk_quiet("abort", 14);
    chk("abort bank", 14, 32'(oBANK_SEL), 0);
    chk("abort stage", 14, 32'(oSTAGE), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLK);
      chk("abort we", 15 + i, 32'(oWE), 0);
      chk("abort busy", 15 + i, 32'(oBUSY), 0);
    end

    // Fresh start after abort runs from stage 0, bank 0
    run_cycles(25, 1'b0);
    chk_quiet("end", 25);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
